// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file and its busy scoreboard.
package regfile_pkg;

   localparam int DEF_WIDTH    = 32;
   localparam int DEF_DEPTH    = 32;
   localparam int DEF_NR       = 2;
   localparam int DEF_NW       = 2;
   localparam int DEF_ZERO_REG = 1;
   localparam int DEF_BYPASS   = 1;

   // Address width; a one-entry file still gets a 1-bit address so ports never collapse.
   function automatic int calc_aw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int DEF_AW = calc_aw(DEF_DEPTH);

   typedef logic [DEF_AW-1:0]    addr_t;
   typedef logic [DEF_WIDTH-1:0] word_t;
   typedef addr_t [DEF_NR-1:0]   rd_addr_arr_t;
   typedef word_t [DEF_NR-1:0]   rd_data_arr_t;
   typedef addr_t [DEF_NW-1:0]   wr_addr_arr_t;
   typedef word_t [DEF_NW-1:0]   wr_data_arr_t;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy bits: set when a producer issues, cleared when a write port retires it.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NR       = DEF_NR,
   parameter int NW       = DEF_NW,
   parameter int ZERO_REG = DEF_ZERO_REG,
   parameter int BYPASS   = DEF_BYPASS,
   localparam int AW      = calc_aw(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NW-1:0]          we,
   input  logic [NW-1:0][AW-1:0]  wa,
   input  logic [NR-1:0][AW-1:0]  ra,
   input  logic                   busy_set,
   input  logic [AW-1:0]          busy_wa,
   output logic [NR-1:0]          rbusy
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   function automatic logic addr_live(input logic [AW-1:0] a);
      return ({1'b0, a} < DEPTH_W) && !(ZERO_REG != 0 && a == '0);
   endfunction

   // Set is applied after the clears so a newly issued producer outranks one retiring now.
   always_comb begin
      for (int e = 0; e < DEPTH; e++) begin
         busy_d[e] = busy_q[e];
         for (int p = 0; p < NW; p++) begin
            if (we[p] && wa[p] == AW'(e)) begin
               busy_d[e] = 1'b0;
            end
         end
         if (busy_set && busy_wa == AW'(e) && !(ZERO_REG != 0 && e == 0)) begin
            busy_d[e] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NR; i++) begin
         rbusy[i] = 1'b0;
         if (!reset && addr_live(ra[i])) begin
            for (int e = 0; e < DEPTH; e++) begin
               if (ra[i] == AW'(e)) begin
                  rbusy[i] = busy_q[e];
               end
            end
            if (BYPASS != 0) begin
               for (int p = 0; p < NW; p++) begin
                  if (we[p] && wa[p] == ra[i]) begin
                     rbusy[i] = 1'b0;
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised NR-read / NW-write register file with optional r0, write bypass and busy scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NR       = DEF_NR,
   parameter int NW       = DEF_NW,
   parameter int ZERO_REG = DEF_ZERO_REG,
   parameter int BYPASS   = DEF_BYPASS,
   localparam int AW      = calc_aw(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NW-1:0]            we,
   input  logic [NW-1:0][AW-1:0]    wa,
   input  logic [NW-1:0][WIDTH-1:0] wd,
   input  logic [NR-1:0][AW-1:0]    ra,
   output logic [NR-1:0][WIDTH-1:0] rd,
   output logic [NR-1:0]            rbusy,
   input  logic                     busy_set,
   input  logic [AW-1:0]            busy_wa
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] rf_q [DEPTH];
   logic [WIDTH-1:0] rf_d [DEPTH];

   function automatic logic addr_live(input logic [AW-1:0] a);
      return ({1'b0, a} < DEPTH_W) && !(ZERO_REG != 0 && a == '0);
   endfunction

   // Ports are scanned in ascending order so the highest-index colliding writer wins.
   always_comb begin
      for (int e = 0; e < DEPTH; e++) begin
         rf_d[e] = rf_q[e];
         for (int p = 0; p < NW; p++) begin
            if (we[p] && wa[p] == AW'(e) && addr_live(wa[p])) begin
               rf_d[e] = wd[p];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int e = 0; e < DEPTH; e++) begin
            rf_q[e] <= '0;
         end
      end else begin
         for (int e = 0; e < DEPTH; e++) begin
            rf_q[e] <= rf_d[e];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NR; i++) begin
         rd[i] = '0;
         if (!reset && addr_live(ra[i])) begin
            for (int e = 0; e < DEPTH; e++) begin
               if (ra[i] == AW'(e)) begin
                  rd[i] = rf_q[e];
               end
            end
            if (BYPASS != 0) begin
               for (int p = 0; p < NW; p++) begin
                  if (we[p] && wa[p] == ra[i]) begin
                     rd[i] = wd[p];
                  end
               end
            end
         end
      end
   end

   rf_scoreboard #(
      .DEPTH    (DEPTH),
      .NR       (NR),
      .NW       (NW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .we       (we),
      .wa       (wa),
      .ra       (ra),
      .busy_set (busy_set),
      .busy_wa  (busy_wa),
      .rbusy    (rbusy)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: a default 2R/2W bypassing file and a 24-entry 3R/1W non-bypassing file
// share stimulus; an array-based reference model predicts every read port each cycle.
module tb_regfile_mp;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]       we;
   logic [1:0][4:0]  wa;
   logic [1:0][31:0] wd;
   logic [1:0][4:0]  ra_a;
   logic [1:0][31:0] rd_a;
   logic [1:0]       rbusy_a;
   logic [2:0][4:0]  ra_b;
   logic [2:0][31:0] rd_b;
   logic [2:0]       rbusy_b;
   logic             busy_set;
   logic [4:0]       busy_wa;

   regfile_mp #(
      .WIDTH(32), .DEPTH(32), .NR(2), .NW(2), .ZERO_REG(1), .BYPASS(1)
   ) dut_a (
      .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra_a), .rd(rd_a),
      .rbusy(rbusy_a), .busy_set(busy_set), .busy_wa(busy_wa)
   );

   regfile_mp #(
      .WIDTH(32), .DEPTH(24), .NR(3), .NW(1), .ZERO_REG(1), .BYPASS(0)
   ) dut_b (
      .clk(clk), .reset(reset), .we(we[0:0]), .wa(wa[0]), .wd(wd[0]), .ra(ra_b), .rd(rd_b),
      .rbusy(rbusy_b), .busy_set(busy_set), .busy_wa(busy_wa)
   );

   typedef struct packed {
      logic [1:0][31:0] rd_a;
      logic [1:0]       rb_a;
      logic [2:0][31:0] rd_b;
      logic [2:0]       rb_b;
   } exp_t;

   exp_t exp_q[$];
   int tests_run = 0;
   int tests_failed = 0;

   logic [31:0] mem_a [32];
   logic [31:0] mem_b [32];
   bit          busy_a [32];
   bit          busy_b [32];

   function automatic logic [31:0] model_rd_a(input logic [4:0] a);
      logic [31:0] v;
      if (reset || a == 5'd0) return 32'd0;
      v = mem_a[a];
      for (int p = 0; p < 2; p++) if (we[p] && wa[p] == a) v = wd[p];
      return v;
   endfunction

   function automatic logic model_rb_a(input logic [4:0] a);
      if (reset || a == 5'd0) return 1'b0;
      for (int p = 0; p < 2; p++) if (we[p] && wa[p] == a) return 1'b0;
      return busy_a[a];
   endfunction

   function automatic logic [31:0] model_rd_b(input logic [4:0] a);
      if (reset || a == 5'd0 || a >= 5'd24) return 32'd0;
      return mem_b[a];
   endfunction

   function automatic logic model_rb_b(input logic [4:0] a);
      if (reset || a == 5'd0 || a >= 5'd24) return 1'b0;
      return busy_b[a];
   endfunction

   function automatic logic [4:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(24, 31));
      return 5'($urandom_range(0, 9));
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      for (int i = 0; i < 2; i++) begin
         cmp($sformatf("a.rd[%0d] ra=%0d", i, ra_a[i]), rd_a[i], e.rd_a[i]);
         cmp($sformatf("a.rbusy[%0d] ra=%0d", i, ra_a[i]), 32'(rbusy_a[i]), 32'(e.rb_a[i]));
      end
      for (int i = 0; i < 3; i++) begin
         cmp($sformatf("b.rd[%0d] ra=%0d", i, ra_b[i]), rd_b[i], e.rd_b[i]);
         cmp($sformatf("b.rbusy[%0d] ra=%0d", i, ra_b[i]), 32'(rbusy_b[i]), 32'(e.rb_b[i]));
      end
   endtask

   // Predict this cycle's outputs, hand them to the monitor, then advance the model at the edge.
   task automatic applyStimulus();
      exp_t e;
      if (reset) begin
         for (int k = 0; k < 32; k++) begin
            mem_a[k] = '0; mem_b[k] = '0; busy_a[k] = 0; busy_b[k] = 0;
         end
      end
      for (int i = 0; i < 2; i++) begin
         e.rd_a[i] = model_rd_a(ra_a[i]);
         e.rb_a[i] = model_rb_a(ra_a[i]);
      end
      for (int i = 0; i < 3; i++) begin
         e.rd_b[i] = model_rd_b(ra_b[i]);
         e.rb_b[i] = model_rb_b(ra_b[i]);
      end
      exp_q.push_back(e);
      @(posedge clk);
      if (!reset) begin
         for (int p = 0; p < 2; p++) if (we[p] && wa[p] != 5'd0) mem_a[wa[p]] = wd[p];
         for (int p = 0; p < 2; p++) if (we[p]) busy_a[wa[p]] = 0;
         if (busy_set && busy_wa != 5'd0) busy_a[busy_wa] = 1;
         if (we[0] && wa[0] != 5'd0 && wa[0] < 5'd24) mem_b[wa[0]] = wd[0];
         if (we[0] && wa[0] < 5'd24) busy_b[wa[0]] = 0;
         if (busy_set && busy_wa != 5'd0 && busy_wa < 5'd24) busy_b[busy_wa] = 1;
      end
      #1;
   endtask

   task automatic idle();
      we = 2'b00;
      busy_set = 1'b0;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      we = '0; wa = '0; wd = '0; ra_a = '0; ra_b = '0; busy_set = 1'b0; busy_wa = '0;
      @(posedge clk);
      #1;
      applyStimulus();
      reset = 1'b0;
      applyStimulus();

      // Reset mid-cycle wipes a written, busy register immediately.
      we = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; ra_a[0] = 5'd5; ra_b[0] = 5'd5;
      busy_set = 1'b1; busy_wa = 5'd5;
      applyStimulus();
      idle(); applyStimulus();
      reset = 1'b1; applyStimulus();
      reset = 1'b0; applyStimulus();

      // Plain write/read: bypass on instance a, old value on b until the edge.
      we = 2'b01; wa[0] = 5'd7; wd[0] = 32'h12345678; ra_a[0] = 5'd7; ra_b[0] = 5'd7;
      applyStimulus();
      idle(); applyStimulus();

      // Hardwired r0 ignores writes and busy marking.
      we = 2'b01; wa[0] = 5'd0; wd[0] = 32'hFFFFFFFF; ra_a[0] = 5'd0; ra_b[0] = 5'd0;
      busy_set = 1'b1; busy_wa = 5'd0;
      applyStimulus();
      idle(); applyStimulus();

      // Two ports writing one register: port 1 wins.
      we = 2'b11; wa[0] = 5'd3; wa[1] = 5'd3; wd[0] = 32'hA; wd[1] = 32'hB;
      ra_a[1] = 5'd3; ra_b[1] = 5'd3;
      applyStimulus();
      idle(); applyStimulus();

      // Scoreboard set, bypass kill, clear, and set-beats-clear on one edge.
      busy_set = 1'b1; busy_wa = 5'd9; ra_a[0] = 5'd9; ra_b[0] = 5'd9;
      applyStimulus();
      idle(); applyStimulus();
      we = 2'b10; wa[1] = 5'd9; wd[1] = 32'h99;
      applyStimulus();
      idle(); applyStimulus();
      busy_set = 1'b1; busy_wa = 5'd9; we = 2'b01; wa[0] = 5'd9; wd[0] = 32'h909;
      applyStimulus();
      idle(); applyStimulus();

      // Out-of-range write on the 24-entry file, then r1..r3 read through all three ports.
      we = 2'b01; wa[0] = 5'd30; wd[0] = 32'hBAD0BAD0; ra_b[0] = 5'd30;
      applyStimulus();
      idle(); applyStimulus();
      for (int r = 1; r <= 3; r++) begin
         we = 2'b01; wa[0] = 5'(r); wd[0] = 32'h100 + 32'(r);
         applyStimulus();
      end
      idle();
      ra_b[0] = 5'd1; ra_b[1] = 5'd2; ra_b[2] = 5'd3;
      applyStimulus();

      for (int n = 0; n < 400; n++) begin
         we = 2'($urandom_range(0, 3));
         for (int p = 0; p < 2; p++) begin
            wa[p] = rand_addr();
            wd[p] = $urandom;
         end
         for (int i = 0; i < 2; i++) ra_a[i] = rand_addr();
         for (int i = 0; i < 3; i++) ra_b[i] = rand_addr();
         busy_set = ($urandom_range(0, 2) == 0);
         busy_wa = rand_addr();
         reset = ($urandom_range(0, 59) == 0);
         applyStimulus();
      end
      reset = 1'b0;
      idle();

      @(negedge clk);
      #1;
      cmp("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
